// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the five-stage pipeline: operand-timing hazards,
// multiply/divide busy tracking and a saturating stalled-cycle counter.
module pipe_stall_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic        d_md,
  input  logic [4:0]  e_wa,
  input  logic [1:0]  e_tnew,
  input  logic [4:0]  m_wa,
  input  logic [1:0]  m_tnew,
  input  logic        e_start,
  input  logic        e_md_op,
  output logic        stall,
  output logic        pc_we,
  output logic        d_we,
  output logic        e_flush,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [3:0]  cnt_reg;
  logic [3:0]  cnt_next;
  logic [31:0] stall_cnt_reg;
  logic [31:0] stall_cnt_next;

  logic [1:0][4:0] src;
  logic [1:0][1:0] tuse;
  logic [1:0]      data_hz;
  logic            md_hz;

  assign src  = {d_rt, d_rs};
  assign tuse = {d_tuse_rt, d_tuse_rs};

  // One hazard detector per source operand; tuse = 3 can never lose the strict compare.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign data_hz[gi] = (src[gi] != 5'd0) &&
                           (((src[gi] == e_wa) && (e_tnew > tuse[gi])) ||
                            ((src[gi] == m_wa) && (m_tnew > tuse[gi])));
    end
  endgenerate

  assign md_busy = (cnt_reg != 4'd0);
  assign md_hz   = d_md && (e_start || md_busy);

  // Forced low in reset so downstream registers load their own reset values.
  assign stall   = !reset && (|data_hz || md_hz);
  assign pc_we   = ~stall;
  assign d_we    = ~stall;
  assign e_flush = stall;

  assign state     = md_busy ? BUSY : IDLE;
  assign stall_cnt = stall_cnt_reg;

  always_comb begin
    cnt_next = cnt_reg;
    case (state)
      IDLE: begin
        if (e_start) cnt_next = e_md_op ? DIV_LD : MULT_LD;
      end
      BUSY: begin
        // A start while busy is illegal (the pipeline is stalled) and is ignored.
        cnt_next = cnt_reg - 4'd1;
      end
      default: cnt_next = 4'd0;
    endcase
  end

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (stall && (stall_cnt_reg != 32'hFFFF_FFFF)) stall_cnt_next = stall_cnt_reg + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg       <= 4'd0;
      stall_cnt_reg <= 32'd0;
    end else begin
      cnt_reg       <= cnt_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: stimulus queues expected outputs, a
// negedge monitor pops and compares them against the DUT.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_rs, d_rt, e_wa, m_wa;
  logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic        d_md, e_start, e_md_op;
  logic        stall, pc_we, d_we, e_flush, md_busy;
  logic [31:0] stall_cnt;

  pipe_stall_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_md(d_md), .e_wa(e_wa), .e_tnew(e_tnew), .m_wa(m_wa), .m_tnew(m_tnew),
    .e_start(e_start), .e_md_op(e_md_op),
    .stall(stall), .pc_we(pc_we), .d_we(d_we), .e_flush(e_flush),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        stall;
    logic        busy;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] ex);
    n_cmp++;
    if (act !== ex) begin
      n_err++;
      $display("FAIL %s.%s got=%h exp=%h", nm, fld, act, ex);
    end
  endtask

  // Monitor: one expected entry per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      chk(cur.name, "stall",     {31'd0, stall},   {31'd0, cur.stall});
      chk(cur.name, "pc_we",     {31'd0, pc_we},   {31'd0, ~cur.stall});
      chk(cur.name, "d_we",      {31'd0, d_we},    {31'd0, ~cur.stall});
      chk(cur.name, "e_flush",   {31'd0, e_flush}, {31'd0, cur.stall});
      chk(cur.name, "md_busy",   {31'd0, md_busy}, {31'd0, cur.busy});
      chk(cur.name, "stall_cnt", stall_cnt,        cur.cnt);
      $display("vec %-12s stall=%b pc_we=%b d_we=%b e_flush=%b md_busy=%b stall_cnt=%h",
               cur.name, stall, pc_we, d_we, e_flush, md_busy, stall_cnt);
    end
  end

  task automatic clr();
    d_rs = 0; d_rt = 0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_md = 0;
    e_wa = 0; e_tnew = 0; m_wa = 0; m_tnew = 0; e_start = 0; e_md_op = 0;
  endtask

  task automatic step(input string nm, input logic s, input logic b, input logic [31:0] c);
    exp_t e;
    e.name = nm; e.stall = s; e.busy = b; e.cnt = c;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    d_rs = 0; d_rt = 0; d_tuse_rs = 0; d_tuse_rt = 0; d_md = 0;
    e_wa = 0; e_tnew = 0; m_wa = 0; m_tnew = 0; e_start = 0; e_md_op = 0;
    @(posedge clk); #1;
    step("rst0", 0, 0, 0);
    step("rst1", 0, 0, 0);
    d_rs = 5; e_wa = 5; e_tnew = 2;            // hazard present but masked by reset
    step("rst_hz", 0, 0, 0);
    reset = 1'b0; clr();
    step("idle", 0, 0, 0);

    // E-stage load-use
    d_rs = 5; d_tuse_rs = 0; e_wa = 5; e_tnew = 2;
    step("lu", 1, 0, 0);
    e_tnew = 0;
    step("lu_tnew0", 0, 0, 1);
    d_rs = 0; e_wa = 0; e_tnew = 2;
    step("lu_rs0", 0, 0, 1);
    d_rs = 5; e_wa = 5; e_tnew = 3; d_tuse_rs = 3;
    step("tuse3", 0, 0, 1);
    d_tuse_rs = 2;
    step("tuse2_tn3", 1, 0, 1);

    // M-stage hazard on rt
    clr(); d_rt = 7; d_tuse_rt = 0; m_wa = 7; m_tnew = 1;
    step("m_hz", 1, 0, 2);
    d_tuse_rt = 1;
    step("m_tuse1", 0, 0, 3);

    // rs and rt hazards together count once
    d_rs = 5; d_tuse_rs = 0; e_wa = 5; e_tnew = 2; d_tuse_rt = 0;
    step("both", 1, 0, 3);
    clr();
    step("clr", 0, 0, 4);

    // Mult: start cycle plus 5 busy cycles stall with d_md held
    d_md = 1; e_start = 1; e_md_op = 0;
    step("mul_start", 1, 0, 4);
    e_start = 0;
    for (int i = 0; i < 5; i++) step($sformatf("mul_busy%0d", i), 1, 1, 32'd5 + 32'(i));
    step("mul_done", 0, 0, 10);

    // Div, then reset after 4 busy cycles
    clr(); e_start = 1; e_md_op = 1;
    step("div_start", 0, 0, 10);
    e_start = 0; e_md_op = 0;
    for (int i = 0; i < 4; i++) step($sformatf("div_busy%0d", i), 0, 1, 10);
    reset = 1'b1; d_md = 1;                    // busy + d_md would stall, reset forces 0
    step("div_rst", 0, 1, 10);
    reset = 1'b0;
    step("div_after", 0, 0, 0);

    // Saturation via backdoor preload
    clr(); d_rs = 5; d_tuse_rs = 0; e_wa = 5; e_tnew = 2;
    force dut.stall_cnt_reg = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_reg;
    step("sat0", 1, 0, 32'hFFFF_FFFE);
    step("sat1", 1, 0, 32'hFFFF_FFFF);
    step("sat2", 1, 0, 32'hFFFF_FFFF);
    clr();
    step("sat_hold", 0, 0, 32'hFFFF_FFFF);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
